// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel coordinates, checks frame timing and emits a registered pixel stream.
// Optional build macro VGA_CAPTURE_CRC_EN adds a per-frame CRC-16-CCITT over the captured colors.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BACK   = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_color,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_count
`ifdef VGA_CAPTURE_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic [0:0]  crc_valid
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
    localparam int H_START = H_PULSE + H_BACK;
    localparam int V_START = V_PULSE + V_BACK;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_OVER  = 10'(H_TOTAL + 1);
    localparam logic [9:0] V_END   = 10'(V_TOTAL);
    localparam logic [9:0] V_OVER  = 10'(V_TOTAL + 1);
    localparam logic [9:0] H_BEGIN = 10'(H_START);
    localparam logic [9:0] H_STOP  = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_BEGIN = 10'(V_START);
    localparam logic [9:0] V_STOP  = 10'(V_START + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      state, state_next;
    logic        frame_bad, frame_bad_next, err_inc;
    logic        hs1, hs2, vs1, vs2;
    logic [11:0] color1;
    logic [9:0]  h_cnt, v_cnt;
    logic        hs_fall, vs_fall, line_err, frame_err, timing_err, window, pix_ok;

    assign hs_fall    = hs2 & ~hs1;
    assign vs_fall    = vs2 & ~vs1;
    assign line_err   = (hs_fall && h_cnt != H_LAST) || (h_cnt == H_OVER);
    assign frame_err  = (vs_fall && v_cnt != V_END) || (v_cnt == V_OVER);
    assign timing_err = line_err | frame_err;
    assign window     = (h_cnt >= H_BEGIN) && (h_cnt < H_STOP) &&
                        (v_cnt >= V_BEGIN) && (v_cnt < V_STOP);
    assign pix_ok     = window & locked;

    // Syncs reset to their idle (high) level so release does not fake an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs1    <= 1'b1;
            hs2    <= 1'b1;
            vs1    <= 1'b1;
            vs2    <= 1'b1;
            color1 <= '0;
        end else begin
            hs1    <= hsync;
            hs2    <= hs1;
            vs1    <= vsync;
            vs2    <= vs1;
            color1 <= {red, green, blue};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hs_fall)
                h_cnt <= '0;
            else if (h_cnt != 10'h3FF)
                h_cnt <= h_cnt + 10'd1;
            if (vs_fall)
                v_cnt <= '0;
            else if (hs_fall && v_cnt != 10'h3FF)
                v_cnt <= v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SEARCH;
            frame_bad <= 1'b0;
        end else begin
            state     <= state_next;
            frame_bad <= frame_bad_next;
        end
    end

    always_comb begin
        state_next     = state;
        frame_bad_next = frame_bad;
        err_inc        = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_next     = ACQUIRE;
                    frame_bad_next = 1'b0;
                end
            end
            ACQUIRE: begin
                if (vs_fall) begin
                    if (v_cnt == V_END && !frame_bad && !timing_err)
                        state_next = LOCKED;
                    frame_bad_next = 1'b0;
                end else if (timing_err) begin
                    frame_bad_next = 1'b1;
                end
            end
            LOCKED: begin
                // An error beats a coincident vs_fall; that edge is not reused for acquisition.
                if (timing_err) begin
                    state_next = SEARCH;
                    err_inc    = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_color   <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            pix_valid   <= pix_ok;
            pix_x       <= pix_ok ? h_cnt - H_BEGIN : '0;
            pix_y       <= pix_ok ? v_cnt - V_BEGIN : '0;
            pix_color   <= pix_ok ? color1 : '0;
            frame_start <= pix_ok && h_cnt == H_BEGIN && v_cnt == V_BEGIN;
            locked      <= (state_next == LOCKED);
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] r;
        r = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (r[15] ^ data[i])
                r = {r[14:0], 1'b0} ^ 16'h1021;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc;
    logic        crc_armed;

    // crc_armed marks a frame whose first pixel was seen while locked and not lost since.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc       <= '0;
            crc_armed <= 1'b0;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (pix_valid)
                crc <= crc_step(frame_start ? 16'hFFFF : crc, {4'b0, pix_color});
            if (state != LOCKED) begin
                crc_armed <= 1'b0;
            end else if (vs_fall && !timing_err && crc_armed) begin
                frame_crc <= crc;
                crc_valid <= 1'b1;
                crc_armed <= 1'b0;
            end else if (frame_start) begin
                crc_armed <= 1'b1;
            end
        end
    end
`endif

endmodule
